// File: rtl/spi_cmd_regfile.sv
// Command decoder and configuration register bank behind the 25-bit SPI slave (sclk domain).
// Optional macro WRITE_ECHO_EN: when defined, writes also return a response frame.
module spi_cmd_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [15:0] ID_VALUE = 16'hE427
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic [24:0]            rx_data,
  input  logic                   rx_ready,
  output logic [24:0]            tx_data,
  output logic                   tx_trigger,
  output logic [16*NUM_REGS-1:0] cfg_regs,
  output logic                   cfg_wr_strobe,
  output logic [7:0]             cfg_wr_addr
);

`ifdef WRITE_ECHO_EN
  localparam bit WRITE_ECHO = 1'b1;
`else
  localparam bit WRITE_ECHO = 1'b0;
`endif

  localparam logic [7:0] ADDR_ID     = 8'd0;
  localparam logic [7:0] ADDR_STATUS = 8'd1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        rx_ready_q;
  logic [24:0] cmd;
  logic [7:0]  err_cnt;
  logic [7:0]  ovr_cnt;
  logic [15:0] regs [NUM_REGS-1:2];

  logic        new_frame;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        addr_valid;
  logic        status_clear;
  logic        rw_write;
  logic        exec_err;
  logic        exec_respond;
  logic [15:0] rd_val;
  logic [15:0] exec_rdata;
  logic [7:0]  err_cnt_next;
  logic [7:0]  ovr_cnt_next;

  assign new_frame    = rx_ready & ~rx_ready_q;
  assign cmd_write    = cmd[24];
  assign cmd_addr     = cmd[23:16];
  assign cmd_wdata    = cmd[15:0];
  assign addr_valid   = int'(cmd_addr) < NUM_REGS;
  assign exec_respond = !cmd_write || WRITE_ECHO;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    rd_val = 16'h0000;
    if (cmd_addr == ADDR_ID)
      rd_val = ID_VALUE;
    else if (cmd_addr == ADDR_STATUS)
      rd_val = {err_cnt, ovr_cnt};
    for (int i = 2; i < NUM_REGS; i++)
      if (cmd_addr == i[7:0]) rd_val = regs[i];
  end

  always_comb begin
    exec_err     = 1'b0;
    exec_rdata   = rd_val;
    status_clear = 1'b0;
    rw_write     = 1'b0;
    if (!addr_valid) begin
      exec_err   = 1'b1;
      exec_rdata = 16'hDEAD;
    end else if (cmd_write) begin
      if (cmd_addr == ADDR_ID) begin
        exec_err   = 1'b1;
        exec_rdata = ID_VALUE;
      end else if (cmd_addr == ADDR_STATUS) begin
        status_clear = 1'b1;
        exec_rdata   = 16'h0000;
      end else begin
        rw_write   = 1'b1;
        exec_rdata = cmd_wdata;
      end
    end
  end

  // A STATUS clear overrides any overrun or error counted in the same cycle.
  always_comb begin
    err_cnt_next = err_cnt;
    ovr_cnt_next = ovr_cnt;
    if (new_frame && state != IDLE && ovr_cnt != 8'hFF)
      ovr_cnt_next = ovr_cnt + 8'd1;
    if (state == EXEC && exec_err && err_cnt != 8'hFF)
      err_cnt_next = err_cnt + 8'd1;
    if (state == EXEC && status_clear) begin
      err_cnt_next = 8'h00;
      ovr_cnt_next = 8'h00;
    end
  end

  // ID and STATUS are not configuration; their slots read as zero.
  always_comb begin
    cfg_regs = '0;
    for (int i = 2; i < NUM_REGS; i++)
      cfg_regs[16*i +: 16] = regs[i];
  end

  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state         <= IDLE;
      rx_ready_q    <= 1'b0;
      cmd           <= '0;
      err_cnt       <= 8'h00;
      ovr_cnt       <= 8'h00;
      tx_data       <= '0;
      tx_trigger    <= 1'b0;
      cfg_wr_strobe <= 1'b0;
      cfg_wr_addr   <= 8'h00;
      // NOTE: the register array is reset explicitly; configuration must come up known, so it cannot map to RAM.
      for (int i = 2; i < NUM_REGS; i++)
        regs[i] <= 16'h0000;
    end else begin
      rx_ready_q    <= rx_ready;
      err_cnt       <= err_cnt_next;
      ovr_cnt       <= ovr_cnt_next;
      tx_trigger    <= 1'b0;
      cfg_wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (new_frame) begin
            cmd   <= rx_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (rw_write) begin
            for (int i = 2; i < NUM_REGS; i++)
              if (cmd_addr == i[7:0]) regs[i] <= cmd_wdata;
            cfg_wr_strobe <= 1'b1;
            cfg_wr_addr   <= cmd_addr;
          end
          if (exec_respond) begin
            tx_data    <= {exec_err, cmd_addr, exec_rdata};
            tx_trigger <= 1'b1;
            state      <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Scoreboard bench for spi_cmd_regfile: directed scenarios then randomized frames vs a transaction-level model.
module tb_spi_cmd_regfile;
  localparam int          NUM_REGS = 16;
  localparam logic [15:0] ID_VALUE = 16'hE427;
`ifdef WRITE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic                   sclk = 1'b0;
  logic                   rst = 1'b1;
  logic [24:0]            rx_data = '0;
  logic                   rx_ready = 1'b0;
  logic [24:0]            tx_data;
  logic                   tx_trigger;
  logic [16*NUM_REGS-1:0] cfg_regs;
  logic                   cfg_wr_strobe;
  logic [7:0]             cfg_wr_addr;

  spi_cmd_regfile #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
    .sclk(sclk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_trigger(tx_trigger), .cfg_regs(cfg_regs),
    .cfg_wr_strobe(cfg_wr_strobe), .cfg_wr_addr(cfg_wr_addr)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct { logic [24:0] data; int cyc; } resp_t;
  typedef struct { logic [7:0] addr; int cyc; } strobe_t;
  resp_t   resp_q[$];
  strobe_t strobe_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference model.
  logic [15:0] m_regs [NUM_REGS];
  int          m_err;
  int          m_ovr;
  int          busy_until;
  logic [24:0] last_resp;

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'h0000;
    m_err = 0;
    m_ovr = 0;
    busy_until = -100;
    last_resp = '0;
    resp_q.delete();
    strobe_q.delete();
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    f = '0;
    for (int i = 2; i < NUM_REGS; i++) f[16*i +: 16] = m_regs[i];
    return f;
  endfunction

  task automatic model_issue(input logic [24:0] frame, input int c);
    bit          w;
    int          a;
    bit          err;
    bit          respond;
    logic [15:0] rdata;
    w = frame[24];
    a = int'(frame[23:16]);
    err = 1'b0;
    if (c <= busy_until) begin
      if (m_ovr < 255) m_ovr++;
      return;
    end
    respond = !w || ECHO;
    if (a >= NUM_REGS) begin
      err = 1'b1; rdata = 16'hDEAD;
    end else if (w && a == 0) begin
      err = 1'b1; rdata = ID_VALUE;
    end else if (w && a == 1) begin
      m_err = 0; m_ovr = 0; rdata = 16'h0000;
    end else if (w) begin
      m_regs[a] = frame[15:0];
      rdata = frame[15:0];
      strobe_q.push_back('{addr: a[7:0], cyc: c + 2});
    end else if (a == 0) begin
      rdata = ID_VALUE;
    end else if (a == 1) begin
      rdata = {m_err[7:0], m_ovr[7:0]};
    end else begin
      rdata = m_regs[a];
    end
    if (err && m_err < 255) m_err++;
    if (respond) begin
      last_resp = {err, a[7:0], rdata};
      resp_q.push_back('{data: last_resp, cyc: c + 2});
    end
    busy_until = c + (respond ? 2 : 1);
  endtask

  task automatic send_frame(input logic [24:0] frame, input int hold, input int gap);
    @(negedge sclk);
    rx_data  = frame;
    rx_ready = 1'b1;
    model_issue(frame, cyc);
    repeat (hold) @(negedge sclk);
    rx_ready = 1'b0;
    repeat (gap - 1) @(negedge sclk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sclk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a write strobe.
  always @(negedge sclk) begin
    if (!rst) begin
      if (tx_trigger) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_trigger_unexpected: got trigger with tx_data %0h, required no trigger", tx_data);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("tx_data", 256'(tx_data), 256'(r.data));
          check("tx_latency", 256'(cyc), 256'(r.cyc));
        end
      end
      if (cfg_wr_strobe) begin
        if (strobe_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_strobe_unexpected: got strobe addr %0h, required no strobe", cfg_wr_addr);
        end else begin
          strobe_t s;
          s = strobe_q.pop_front();
          check("cfg_wr_addr", 256'(cfg_wr_addr), 256'(s.addr));
          check("wr_strobe_latency", 256'(cyc), 256'(s.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle(3);
    rst = 1'b0;
    check("reset_tx_data", 256'(tx_data), 256'(0));
    check("reset_tx_trigger", 256'(tx_trigger), 256'(0));
    check("reset_cfg_regs", cfg_regs, 256'(0));
    check("reset_wr_addr", 256'(cfg_wr_addr), 256'(0));

    // Read ID.
    send_frame(25'h0000000, 1, 3);
    // Write reg 3, read it back.
    send_frame(25'h1030BEF, 1, 3);
    send_frame(25'h0030000, 1, 3);
    idle(2);
    check("cfg_reg3", 256'(cfg_regs[63:48]), 256'(16'h0BEF));
    // Error cases, then STATUS.
    send_frame(25'h1001234, 1, 3);
    send_frame(25'h0FF0000, 2, 3);
    send_frame(25'h0010000, 1, 3);
    idle(2);
    check("cfg_after_errors", cfg_regs, model_flat());
    // Held level gives one frame; a re-pulse while busy is an overrun.
    send_frame(25'h0000000, 10, 2);
    send_frame(25'h0000000, 1, 1);
    send_frame(25'h0000000, 1, 3);
    send_frame(25'h0010000, 1, 3);
    // STATUS clear.
    send_frame(25'h1010000, 1, 3);
    send_frame(25'h0010000, 1, 3);
    send_frame(25'h1057777, 1, 3);
    idle(2);
    check("cfg_before_reset", cfg_regs, model_flat());

    // Reset during EXEC: the in-flight read must not respond.
    @(negedge sclk);
    rx_data  = 25'h0030000;
    rx_ready = 1'b1;
    @(negedge sclk);
    rst      = 1'b1;
    rx_ready = 1'b0;
    model_reset();
    @(negedge sclk);
    check("midrst_tx_trigger", 256'(tx_trigger), 256'(0));
    check("midrst_cfg_regs", cfg_regs, 256'(0));
    check("midrst_tx_data", 256'(tx_data), 256'(0));
    @(negedge sclk);
    rst = 1'b0;
    idle(2);
    send_frame(25'h0010000, 1, 3);

    // Write to reg 2: without echo, tx_data holds the previous response.
    send_frame(25'h0000000, 1, 3);
    send_frame(25'h1025555, 1, 4);
    check("cfg_reg2", 256'(cfg_regs[47:32]), 256'(16'h5555));
    check("tx_data_hold", 256'(tx_data), 256'(last_resp));

    // Randomized frames, including back-to-back overruns.
    for (int k = 0; k < 300; k++) begin
      int          sel;
      logic [7:0]  a;
      bit          w;
      sel = int'($urandom_range(0, 9));
      w   = 1'($urandom_range(0, 1));
      case (sel)
        0:       a = 8'd0;
        1:       a = 8'd1;
        2:       a = 8'($urandom_range(NUM_REGS, 255));
        default: a = 8'($urandom_range(2, NUM_REGS - 1));
      endcase
      if (a == 8'd1 && w && $urandom_range(0, 3) != 0) w = 1'b0;
      send_frame({w, a, 16'($urandom)}, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      if (k % 50 == 49) begin
        idle(3);
        check("rand_cfg_regs", cfg_regs, model_flat());
      end
    end
    send_frame(25'h0010000, 1, 3);
    idle(6);
    check("final_cfg_regs", cfg_regs, model_flat());
    check("resp_q_drained", 256'(resp_q.size()), 256'(0));
    check("strobe_q_drained", 256'(strobe_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
